// File: rtl/ipg_tx_sched_pkg.sv
// +----------------------------------------------------------------------+
// | ipg_pkg : block-type codes, class/source nibbles, scheduler states   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ipg_pkg;

  localparam logic [7:0] c_bt_req_first = 8'h0a;
  localparam logic [7:0] c_bt_rsp_first = 8'h0b;
  localparam logic [7:0] c_bt_oth_first = 8'h0c;
  localparam logic [7:0] c_bt_req_mid   = 8'h1a;
  localparam logic [7:0] c_bt_rsp_mid   = 8'h1b;
  localparam logic [7:0] c_bt_oth_mid   = 8'h1c;
  localparam logic [7:0] c_bt_req_last  = 8'h2a;
  localparam logic [7:0] c_bt_rsp_last  = 8'h2b;
  localparam logic [7:0] c_bt_oth_last  = 8'h2c;

  localparam logic [3:0] c_cls_first = 4'h0;
  localparam logic [3:0] c_cls_mid   = 4'h1;
  localparam logic [3:0] c_cls_last  = 4'h2;

  localparam logic [3:0] c_src_req = 4'ha;
  localparam logic [3:0] c_src_rsp = 4'hb;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCK_REQ = 2'd1,
    ST_LOCK_RSP = 2'd2
  } sched_state_t;

  function automatic logic is_last(input logic [7:0] bt);
    return bt[7:4] == c_cls_last;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ipg_tx_sched_if.sv
// +----------------------------------------------------------------------+
// | ipg_tx_sched_if : request/response sources, PHY slot and tx bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface ipg_tx_sched_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int CREDIT_WIDTH = 4
);
  logic                    req_valid;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_ready;
  logic                    slot_avail;
  logic                    credit_return;
  logic                    tx_valid;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    proto_err;

  modport master (
    output req_valid, req_data, rsp_valid, rsp_data, slot_avail, credit_return,
    input  req_ready, rsp_ready, tx_valid, tx_data, credits, proto_err
  );

  modport slave (
    input  req_valid, req_data, rsp_valid, rsp_data, slot_avail, credit_return,
    output req_ready, rsp_ready, tx_valid, tx_data, credits, proto_err
  );
endinterface

`default_nettype wire

// File: rtl/ipg_tx_sched_credit_counter.sv
// +----------------------------------------------------------------------+
// | ipg_credit_counter : request credits mirroring remote job-queue room |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ipg_credit_counter #(
  parameter int CREDIT_WIDTH = 4,
  parameter int INIT_CREDITS = 6
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  input  wire logic                    consume,
  input  wire logic                    give,
  output logic [CREDIT_WIDTH-1:0]      count,
  output logic                         nonzero,
  output logic                         overflow
);

  localparam logic [CREDIT_WIDTH-1:0] c_init = CREDIT_WIDTH'(INIT_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] c_one  = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] r_count;

  // A return beyond the queue depth means the remote freed an entry it never had.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= c_init;
    end else if (consume && !give && r_count != '0) begin
      r_count <= r_count - c_one;
    end else if (give && !consume && r_count != c_init) begin
      r_count <= r_count + c_one;
    end
  end

  assign count    = r_count;
  assign nonzero  = (r_count != '0);
  assign overflow = give && !consume && (r_count == c_init);

endmodule

`default_nettype wire

// File: rtl/ipg_tx_sched.sv
// +----------------------------------------------------------------------+
// | ipg_tx_sched : round-robin, message-atomic IPG slot scheduler        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ipg_tx_sched
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int CREDIT_WIDTH = 4,
  parameter int INIT_CREDITS = 6
) (
  input wire logic       clk,
  input wire logic       reset_n,
  ipg_tx_sched_if.slave  bus
);

  sched_state_t          r_state;
  logic                  r_rr;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_proto_err;

  logic [7:0]            w_req_bt, w_rsp_bt;
  logic                  w_req_bad, w_rsp_bad, w_req_elig, w_rsp_elig;
  logic                  w_req_ready, w_rsp_ready, w_drop;
  logic                  w_req_xfer, w_rsp_xfer, w_fwd, w_consume;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [CREDIT_WIDTH-1:0] w_count;
  logic                  w_nonzero, w_overflow;

  assign w_req_bt   = bus.req_data[7:0];
  assign w_rsp_bt   = bus.rsp_data[7:0];
  assign w_req_bad  = bus.req_valid && (w_req_bt != c_bt_req_first);
  assign w_rsp_bad  = bus.rsp_valid && (w_rsp_bt != c_bt_rsp_first);
  assign w_req_elig = bus.req_valid && (w_req_bt == c_bt_req_first) && w_nonzero;
  assign w_rsp_elig = bus.rsp_valid && (w_rsp_bt == c_bt_rsp_first);

  // Malformed heads are flushed ahead of any grant so only one ready is ever high.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_ready = 1'b0;
    w_drop      = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_bad) begin
            w_req_ready = 1'b1;
            w_drop      = 1'b1;
          end else if (w_rsp_bad) begin
            w_rsp_ready = 1'b1;
            w_drop      = 1'b1;
          end else if (bus.slot_avail) begin
            if (w_req_elig && (!w_rsp_elig || !r_rr)) begin
              w_req_ready = 1'b1;
            end else if (w_rsp_elig) begin
              w_rsp_ready = 1'b1;
            end
          end
        end
        ST_LOCK_REQ: w_req_ready = bus.slot_avail && bus.req_valid;
        ST_LOCK_RSP: w_rsp_ready = bus.slot_avail && bus.rsp_valid;
        default: ;
      endcase
    end
  end

  assign w_req_xfer = w_req_ready && bus.req_valid;
  assign w_rsp_xfer = w_rsp_ready && bus.rsp_valid;
  assign w_fwd      = (w_req_xfer || w_rsp_xfer) && !w_drop;
  assign w_fwd_data = w_req_xfer ? bus.req_data : bus.rsp_data;
  assign w_consume  = w_req_xfer && !w_drop && (w_req_bt == c_bt_req_first);

  ipg_credit_counter #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .INIT_CREDITS (INIT_CREDITS)
  ) u_credits (
    .clk      (clk),
    .reset_n  (reset_n),
    .consume  (w_consume),
    .give     (bus.credit_return),
    .count    (w_count),
    .nonzero  (w_nonzero),
    .overflow (w_overflow)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rr        <= 1'b1;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_tx_valid <= w_fwd;
      if (w_fwd) begin
        r_tx_data <= w_fwd_data;
      end
      if (w_drop || w_overflow) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_req_xfer && !w_drop) begin
            r_state <= ST_LOCK_REQ;
          end else if (w_rsp_xfer && !w_drop) begin
            r_state <= ST_LOCK_RSP;
          end
        end
        ST_LOCK_REQ: begin
          if (w_req_xfer && is_last(w_req_bt)) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b1;
          end
        end
        ST_LOCK_RSP: begin
          if (w_rsp_xfer && is_last(w_rsp_bt)) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_ready = w_rsp_ready;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;
  assign bus.credits   = w_count;
  assign bus.proto_err = r_proto_err;

endmodule

`default_nettype wire
